// File: rtl/aes_pkg.sv
// Shared AES-128 widths and loader state encoding for the word-serial front end.
package aes_pkg;

  localparam int AES_BLK_W         = 128;
  localparam int AES_WORD_W        = 32;
  localparam int AES_WORDS_PER_BLK = 4;
  localparam int AES_WCNT_W        = $clog2(AES_WORDS_PER_BLK);

  localparam logic [AES_WCNT_W-1:0] WCNT_LAST = AES_WCNT_W'(AES_WORDS_PER_BLK - 1);

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_PT,
    PRESENT
  } loader_state_e;

endpackage

// File: rtl/aes_input_loader_if.sv
// Word-in / block-out handshake bundle of the AES input loader.
// newKey exists only when AES_KEY_REUSE_EN is defined.
interface aes_input_loader_if;
  import aes_pkg::*;

  logic                  inValid;
  logic                  inReady;
  logic [AES_WORD_W-1:0] inWord;
  logic                  outValid;
  logic                  outReady;
  logic [0:AES_BLK_W-1]  rndDataOut;
  logic [0:AES_BLK_W-1]  rk0;
`ifdef AES_KEY_REUSE_EN
  logic                  newKey;

  modport master (
    output inValid, inWord, outReady, newKey,
    input  inReady, outValid, rndDataOut, rk0
  );

  modport slave (
    input  inValid, inWord, outReady, newKey,
    output inReady, outValid, rndDataOut, rk0
  );
`else
  modport master (
    output inValid, inWord, outReady,
    input  inReady, outValid, rndDataOut, rk0
  );

  modport slave (
    input  inValid, inWord, outReady,
    output inReady, outValid, rndDataOut, rk0
  );
`endif

endinterface

// File: rtl/aes_word_packer.sv
// 128-bit word shift register: each load shifts one 32-bit word in at the low end,
// so after four loads the first word sits in bits [0:31].
module aes_word_packer
  import aes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_i,
  input  logic                  clr_i,
  input  logic [AES_WORD_W-1:0] word_i,
  output logic [0:AES_BLK_W-1]  blk_o
);

  logic [0:AES_BLK_W-1] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (ld_i) begin
      data_d = {data_q[AES_WORD_W:AES_BLK_W-1], word_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  // Block as it stands after this edge, so a capture includes the word arriving now.
  assign blk_o = data_d;

endmodule

// File: rtl/aes_input_loader.sv
// AES-128 word-serial input loader: packs key and plaintext words, applies the
// round-0 AddRoundKey and presents the block. AES_KEY_REUSE_EN enables key reuse via newKey.
module aes_input_loader
  import aes_pkg::*;
(
  input logic               clk,
  input logic               rst,
  aes_input_loader_if.slave bus
);

  loader_state_e         state_q, state_d;
  logic [AES_WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [0:AES_BLK_W-1]  rnd_q, rk0_q;
  logic [0:AES_BLK_W-1]  key_blk, pt_blk;
  logic                  key_ld, pt_ld, key_clr, pt_clr, capture;
  logic                  reuse_key;

`ifdef AES_KEY_REUSE_EN
  assign reuse_key = !bus.newKey;
`else
  assign reuse_key = 1'b0;
`endif

  aes_word_packer u_key_packer (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (key_ld),
    .clr_i  (key_clr),
    .word_i (bus.inWord),
    .blk_o  (key_blk)
  );

  aes_word_packer u_pt_packer (
    .clk    (clk),
    .rst    (rst),
    .ld_i   (pt_ld),
    .clr_i  (pt_clr),
    .word_i (bus.inWord),
    .blk_o  (pt_blk)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    key_ld  = 1'b0;
    pt_ld   = 1'b0;
    key_clr = 1'b0;
    pt_clr  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      LOAD_KEY: begin
        if (bus.inValid) begin
          key_ld = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_LAST) begin
            state_d = LOAD_PT;
            wcnt_d  = '0;
          end
        end
      end
      LOAD_PT: begin
        if (bus.inValid) begin
          pt_ld  = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == WCNT_LAST) begin
            state_d = PRESENT;
            wcnt_d  = '0;
            capture = 1'b1;
          end
        end
      end
      PRESENT: begin
        if (bus.outReady) begin
          pt_clr = 1'b1;
          wcnt_d = '0;
          // A retained key skips straight to plaintext loading.
          if (reuse_key) begin
            state_d = LOAD_PT;
          end else begin
            state_d = LOAD_KEY;
            key_clr = 1'b1;
          end
        end
      end
      default: begin
        state_d = LOAD_KEY;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_KEY;
      wcnt_q  <= '0;
      rnd_q   <= '0;
      rk0_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (capture) begin
        rnd_q <= pt_blk ^ key_blk;
        rk0_q <= key_blk;
      end
    end
  end

  assign bus.inReady    = (state_q != PRESENT);
  assign bus.outValid   = (state_q == PRESENT);
  assign bus.rndDataOut = rnd_q;
  assign bus.rk0        = rk0_q;

endmodule

// File: tb/tb_aes_input_loader.sv
// Randomised and directed bench for aes_input_loader against a word-queue model.
module tb_aes_input_loader;
  import aes_pkg::*;

`ifdef AES_KEY_REUSE_EN
  localparam bit REUSE_BUILD = 1'b1;
`else
  localparam bit REUSE_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_input_loader_if bus ();

  aes_input_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int nblk       = 0;

  // Model: collected words, whether a block is on the output, retained key.
  logic [31:0]   mwords[$];
  bit            m_present;
  bit            m_reuse;
  logic [0:127]  m_key, m_out, m_rk;

  int   rises[$];
  bit   prev_valid;
  logic [31:0] blk [8];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mwords.delete();
    m_present = 1'b0;
    m_reuse   = 1'b0;
    m_key     = '0;
    m_out     = '0;
    m_rk      = '0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] w, input bit ordy, input bit nk);
    logic [0:127] pt;
    if (m_present) begin
      if (ordy) begin
        m_present = 1'b0;
        m_reuse   = REUSE_BUILD && !nk;
        mwords.delete();
      end
    end else if (v) begin
      mwords.push_back(w);
      if (mwords.size() == (m_reuse ? 4 : 8)) begin
        if (m_reuse) begin
          pt = {mwords[0], mwords[1], mwords[2], mwords[3]};
        end else begin
          m_key = {mwords[0], mwords[1], mwords[2], mwords[3]};
          pt    = {mwords[4], mwords[5], mwords[6], mwords[7]};
        end
        m_out     = pt ^ m_key;
        m_rk      = m_key;
        m_present = 1'b1;
        mwords.delete();
      end
    end
  endtask

  task automatic compare_all();
    chk("inReady",    bus.inReady,    !m_present);
    chk("outValid",   bus.outValid,   m_present);
    chk("rndDataOut", bus.rndDataOut, m_out);
    chk("rk0",        bus.rk0,        m_rk);
    if (bus.outValid && !prev_valid) begin
      rises.push_back(cyc);
      nblk++;
      $display("blk %0d cyc %0d rnd=%h rk0=%h", nblk, cyc, bus.rndDataOut, bus.rk0);
    end
    prev_valid = bus.outValid;
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, check at the next falling edge.
  task automatic cycle(input bit v, input logic [31:0] w, input bit ordy, input bit nk);
    bus.inValid  = v;
    bus.inWord   = w;
    bus.outReady = ordy;
`ifdef AES_KEY_REUSE_EN
    bus.newKey   = nk;
`endif
    model_step(v, w, ordy, nk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.inValid = 1'b0;
    model_reset();
    repeat (2) begin
      @(negedge clk);
      cyc++;
      compare_all();
    end
    rst = 1'b0;
  endtask

  task automatic send_blk(input int first, input int n, input bit gap, input bit ordy);
    for (int i = first; i < first + n; i++) begin
      cycle(1'b1, blk[i], ordy, 1'b1);
      if (gap && i != first + n - 1) cycle(1'b0, $urandom, ordy, 1'b1);
    end
  endtask

  task automatic load_fips();
    blk[0] = 32'h2b7e1516; blk[1] = 32'h28aed2a6; blk[2] = 32'habf71588; blk[3] = 32'h09cf4f3c;
    blk[4] = 32'h3243f6a8; blk[5] = 32'h885a308d; blk[6] = 32'h313198a2; blk[7] = 32'he0370734;
  endtask

  task automatic chk_fips(input string tag);
    chk({tag, "_valid"}, bus.outValid,   1'b1);
    chk({tag, "_rnd"},   bus.rndDataOut, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808);
    chk({tag, "_rk0"},   bus.rk0,        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
  endtask

  initial begin
    int n0;
    bus.inValid  = 1'b0;
    bus.inWord   = '0;
    bus.outReady = 1'b0;
`ifdef AES_KEY_REUSE_EN
    bus.newKey   = 1'b1;
`endif
    prev_valid = 1'b0;
    do_reset();

    // FIPS-197 App. B vector, presented one cycle after the last word.
    load_fips();
    send_blk(0, 8, 1'b0, 1'b1);
    chk_fips("fips");
    cycle(1'b0, '0, 1'b1, 1'b1);
    chk("fips_ready_after_hs", bus.inReady, 1'b1);

    // Backpressure: held outputs, nothing consumed while presenting.
    for (int i = 0; i < 8; i++) blk[i] = $urandom;
    send_blk(0, 8, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b1);
    chk("bp_ready_low", bus.inReady, 1'b0);
    cycle(1'b1, $urandom, 1'b1, 1'b1);
    chk("bp_ready_back", bus.inReady, 1'b1);

    // Gapped input.
    load_fips();
    send_blk(0, 8, 1'b1, 1'b1);
    chk_fips("gap");
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Reset after 5 words, then a full fresh block.
    for (int i = 0; i < 8; i++) blk[i] = $urandom;
    send_blk(0, 5, 1'b0, 1'b1);
    do_reset();
    chk("rst_rnd_zero", bus.rndDataOut, 128'h0);
    load_fips();
    send_blk(0, 8, 1'b0, 1'b1);
    chk_fips("rst");

`ifdef AES_KEY_REUSE_EN
    // Key reuse: newKey=0 at the handshake, then plaintext only.
    cycle(1'b0, '0, 1'b1, 1'b0);
    blk[4] = 32'h00112233; blk[5] = 32'h44556677; blk[6] = 32'h8899aabb; blk[7] = 32'hccddeeff;
    send_blk(4, 4, 1'b0, 1'b1);
    chk("reuse_rnd", bus.rndDataOut, 128'h2b6f3725_6cfbb4d1_236ebf33_c512a1c3);
    chk("reuse_rk0", bus.rk0,        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    chk("reuse_spacing", 128'(rises[$] - rises[$-1]), 128'd5);
`endif
    cycle(1'b0, '0, 1'b1, 1'b1);

    // Three back-to-back blocks with outReady tied high.
    n0 = rises.size();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) blk[i] = $urandom;
      send_blk(0, 8, 1'b0, 1'b1);
      cycle(1'b1, $urandom, 1'b1, 1'b1);
    end
    chk("b2b_pulses", 128'(rises.size() - n0), 128'd3);
    if (rises.size() - n0 == 3) begin
      chk("b2b_space1", 128'(rises[n0+1] - rises[n0]),   128'd9);
      chk("b2b_space2", 128'(rises[n0+2] - rises[n0+1]), 128'd9);
    end

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_input_loader.md
# aes_input_loader

Word-serial front end of the unrolled AES-128 encryption pipeline. Accepts the cipher key and plaintext as 32-bit words over a valid/ready handshake and assembles them into 128-bit blocks. Performs the initial (round-0) AddRoundKey, then presents the whitened state and the round-0 key to the first round stage as `rndDataIn` / `prevRK`. It is the only handshaked boundary ahead of the round chain.

## Interface
Parameters:
- none; widths are fixed by AES-128 and taken from the shared package.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `inValid`  in  1  `inWord` is valid this cycle.
- `inReady`  out  1  loader can accept a word this cycle.
- `inWord`  in  32  key or plaintext word; first word maps to bits [0:31].
- `outValid`  out  1  `rndDataOut` and `rk0` hold a complete block.
- `outReady`  in  1  downstream accepts the block this cycle.
- `rndDataOut`  out  [0:127]  plaintext XOR key; feeds round 1 `rndDataIn`.
- `rk0`  out  [0:127]  round-0 key; feeds round 1 `prevRK`.
- `newKey`  in  1  present only with `AES_KEY_REUSE_EN`; see Configuration.

## Operation
- FSM states are `LOAD_KEY`, `LOAD_PT` and `PRESENT`. A 2-bit word counter `wcnt` tracks position within a block.
- A word transfers when `inValid && inReady`. `inReady = (state != PRESENT)`.
- `LOAD_KEY`:
  - Each transfer shifts the word into the key register at offset `wcnt*32`, with bit 0 as MSB and big-endian word order.
  - When `wcnt==3` transfers: go to `LOAD_PT` and set `wcnt` to 0.
- `LOAD_PT`:
  - Each transfer shifts the word into the plaintext register the same way.
  - When `wcnt==3` transfers: go to `PRESENT`. On the same edge register `rndDataOut <= pt ^ key` (including the final word) and `rk0 <= key`.
- `PRESENT`:
  - `outValid=1`. `rndDataOut` and `rk0` stay stable until `outReady`.
  - When `outValid && outReady`: go to `LOAD_KEY` (default build) and set `wcnt` to 0.
- An idle `inValid=0` cycle in any load state holds all state. Gaps between words are allowed.
- Words offered while in `PRESENT` are not accepted, because `inReady=0`.
- Reset mid-load discards any partial block. No partial output is ever produced.

## Timing
- Reset values:
  - state `LOAD_KEY`, `wcnt=0`.
  - `inReady=1`, `outValid=0`.
  - `rndDataOut`, `rk0` and the key and plaintext registers are all 0.
- Latency: `outValid` rises on the cycle after the 8th word transfers.
- Best-case throughput is 9 cycles per block: 8 word cycles plus 1 present cycle, with `outReady` tied high.
- `inReady` returns to 1 on the cycle after the output handshake.
- All outputs are registered or decoded from registered state. There is no combinational path from `inValid` or `outReady` to any output.

## Configuration
- `AES_KEY_REUSE_EN` undefined:
  - Every block loads 4 key words then 4 plaintext words.
  - The `newKey` port is absent.
- `AES_KEY_REUSE_EN` defined:
  - The `newKey` port is present and is sampled at the output handshake.
  - `newKey=1`: next state is `LOAD_KEY`.
  - `newKey=0`: next state is `LOAD_PT`, and the retained key is reused. A stream then costs 5 cycles per block.
  - The first block after reset always starts in `LOAD_KEY`.

## Structure
- The shared package `aes_pkg` holds:
  - `AES_BLK_W=128` and `AES_WORD_W=32`.
  - `AES_WORDS_PER_BLK=4`.
  - The loader state enum (`LOAD_KEY`, `LOAD_PT`, `PRESENT`).
- One sub-module is natural: `aes_word_packer`, a 128-bit word shift register with load enable and clear. It is instantiated twice, once for key and once for plaintext.

## Test plan
- FIPS-197 App. B vector:
  - Stimulus: key `2b7e1516 28aed2a6 abf71588 09cf4f3c`, then pt `3243f6a8 885a308d 313198a2 e0370734`, with `outReady=1`.
  - Response: `rndDataOut=193de3be a0f4e22b 9ac68d2a e9f84808` and `rk0=2b7e1516…09cf4f3c`, 1 cycle after the last word.
- Backpressure:
  - Stimulus: hold `outReady=0` for 10 cycles while `inValid=1`.
  - Response: `inReady=0`, outputs stable and no word consumed. Accepted on the first `outReady=1` cycle, with `inReady=1` the next cycle.
- Gapped input:
  - Stimulus: `inValid` toggling 1/0 across the 8 words.
  - Response: same result as the App. B vector, with `outValid` 1 cycle after the 8th transfer.
- Reset mid-load:
  - Stimulus: assert `rst` after 5 words, then send a full fresh block.
  - Response: outputs 0 during reset, then a correct block from the fresh 8 words only.
- Key reuse (`AES_KEY_REUSE_EN` defined):
  - Stimulus: `newKey=0` at the handshake, then pt `00112233 44556677 8899aabb ccddeeff`.
  - Response: `rk0` unchanged, `rndDataOut = pt ^ 2b7e…4f3c`, presented 5 cycles after the previous handshake.
- Back-to-back blocks:
  - Stimulus: 3 consecutive blocks with `outReady=1`.
  - Response: exactly 3 `outValid` pulses spaced 9 cycles apart, each with correct data.
